// File: rtl/nmi_mbox_resp.sv
// nmi_mbox_resp: NMI slave mailbox with TX/RX stream FIFOs, status/control registers and a level interrupt.
module nmi_mbox_resp #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int DEPTH = 4,
  parameter int WAIT_CYC = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        nmi_valid_i,
  output logic        nmi_ready_o,
  input  logic [31:0] nmi_addr_i,
  input  logic [31:0] nmi_wdata_i,
  input  logic [3:0]  nmi_wstrb_i,
  output logic [31:0] nmi_rdata_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] tx_data_o,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic [31:0] rx_data_i,
  output logic        irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] FULL = 5'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [2:0] wcnt;
  logic [1:0] off_q;
  logic [31:0] wdata_q;
  logic [3:0] wstrb_q;
  logic [31:0] tx_mem [DEPTH];
  logic [31:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_rp, tx_wp, rx_rp, rx_wp;
  logic [4:0] tx_cnt, rx_cnt;
  logic tx_ovf, rx_udf, rx_ie, txe_ie;
  logic sel, go, rd, tx_full, tx_empty, rx_full, rx_empty;
  logic tx_pop, tx_wr, tx_push, ovf_set, rx_push, rx_rd, rx_pop, udf_set, st_wr, ct_wr, flush;
  logic [1:0] off;
  logic [31:0] wd, status, rval;
  logic [3:0] ws;
  logic unused;
  assign unused = ^nmi_addr_i[1:0];
  assign sel = nmi_valid_i & (nmi_addr_i[31:4] == BASE_ADDR[31:4]);
  assign go = (state == IDLE & sel & WAIT_CYC == 0) | (state == WAIT & wcnt == 3'd0);
  // with no wait states the access completes on the sampling edge, so use the live request
  assign off = state == IDLE ? nmi_addr_i[3:2] : off_q;
  assign wd = state == IDLE ? nmi_wdata_i : wdata_q;
  assign ws = state == IDLE ? nmi_wstrb_i : wstrb_q;
  assign rd = ws == 4'b0000;
  assign tx_full = tx_cnt == FULL;
  assign tx_empty = tx_cnt == 5'd0;
  assign rx_full = rx_cnt == FULL;
  assign rx_empty = rx_cnt == 5'd0;
  assign tx_valid_o = !tx_empty;
  assign tx_data_o = tx_mem[tx_rp];
  assign rx_ready_o = !rx_full;
  assign irq_o = (rx_ie & !rx_empty) | (txe_ie & tx_empty);
  assign tx_pop = tx_valid_o & tx_ready_i;
  assign tx_wr = go & off == 2'd0 & !rd;
  assign tx_push = tx_wr & (!tx_full | tx_pop);
  assign ovf_set = tx_wr & tx_full & !tx_pop;
  assign rx_push = rx_valid_i & rx_ready_o;
  assign rx_rd = go & off == 2'd1 & rd;
  assign rx_pop = rx_rd & !rx_empty;
  assign udf_set = rx_rd & rx_empty;
  assign st_wr = go & off == 2'd2 & ws[3];
  assign ct_wr = go & off == 2'd3 & ws[0];
  assign flush = go & off == 2'd3 & ws[1] & wd[8];
  assign status = {6'b0, rx_udf, tx_ovf, 4'b0, rx_empty, rx_full, tx_empty, tx_full,
                   3'b0, rx_cnt, 3'b0, tx_cnt};
  always_comb begin
    rval = off == 2'd1 ? (rx_empty ? 32'd0 : rx_mem[rx_rp]) :
           off == 2'd2 ? status :
           off == 2'd3 ? {30'd0, txe_ie, rx_ie} : 32'd0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      wcnt <= 3'd0;
      off_q <= 2'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      nmi_ready_o <= 1'b0;
      nmi_rdata_o <= 32'd0;
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
      rx_ie <= 1'b0;
      txe_ie <= 1'b0;
    end else begin
      state <= go ? RESP : state == RESP ? IDLE : (state == IDLE & sel) ? WAIT : state;
      wcnt <= state == WAIT ? wcnt - 3'd1 : 3'(WAIT_CYC - 1);
      if (state == IDLE) begin
        off_q <= nmi_addr_i[3:2];
        wdata_q <= nmi_wdata_i;
        wstrb_q <= nmi_wstrb_i;
      end
      nmi_ready_o <= go;
      if (go) nmi_rdata_o <= rd ? rval : 32'd0;
      tx_ovf <= ovf_set | (tx_ovf & !(st_wr & wd[24]));
      rx_udf <= udf_set | (rx_udf & !(st_wr & wd[25]));
      if (ct_wr) begin
        rx_ie <= wd[0];
        txe_ie <= wd[1];
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i | flush) begin
      tx_rp <= '0;
      tx_wp <= '0;
      tx_cnt <= 5'd0;
      rx_rp <= '0;
      rx_wp <= '0;
      rx_cnt <= 5'd0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + 5'(tx_push) - 5'(tx_pop);
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + 5'(rx_push) - 5'(rx_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (tx_push & !rst_i & !flush) tx_mem[tx_wp] <= wd;
    if (rx_push & !rst_i & !flush) rx_mem[rx_wp] <= rx_data_i;
  end
endmodule

// File: tb/tb_nmi_mbox_resp.sv
// tb_nmi_mbox_resp: queue-based mailbox model compared every cycle, plus directed literal checks.
module tb_nmi_mbox_resp;
  localparam logic [31:0] B = 32'h1000_0000;
  localparam int D = 4;
  localparam int WC = 2;
  localparam logic [31:0] TXD = B, RXD = B + 32'h4, STS = B + 32'h8, CTL = B + 32'hC;
  logic clk_i, rst_i, nmi_valid_i, nmi_ready_o, tx_valid_o, tx_ready_i, rx_valid_i, rx_ready_o, irq_o;
  logic [31:0] nmi_addr_i, nmi_wdata_i, nmi_rdata_o, tx_data_o, rx_data_i;
  logic [3:0] nmi_wstrb_i;
  int checks = 0, failures = 0;
  nmi_mbox_resp #(.BASE_ADDR(B), .DEPTH(D), .WAIT_CYC(WC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .nmi_valid_i(nmi_valid_i), .nmi_ready_o(nmi_ready_o),
    .nmi_addr_i(nmi_addr_i), .nmi_wdata_i(nmi_wdata_i), .nmi_wstrb_i(nmi_wstrb_i),
    .nmi_rdata_o(nmi_rdata_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .tx_data_o(tx_data_o), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .rx_data_i(rx_data_i), .irq_o(irq_o));
  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  logic [31:0] txq[$], rxq[$];
  bit m_ovf, m_udf, m_rxie, m_txeie, started = 0, exp_ready;
  logic [31:0] exp_rdata;
  int left;
  logic [1:0] r_off;
  logic [31:0] r_wd;
  logic [3:0] r_ws;
  always @(posedge clk_i) begin : model
    bit acc, txpop, rxpush, fl;
    logic [31:0] st, rv;
    if (rst_i) begin
      txq.delete();
      rxq.delete();
      {m_ovf, m_udf, m_rxie, m_txeie, exp_ready} = '0;
      exp_rdata = 0;
      left = 0;
      started = 1;
    end else begin
      fl = 0;
      rv = 0;
      if (left > 0) left--;
      else if (nmi_valid_i && nmi_addr_i[31:4] == B[31:4]) begin
        r_off = nmi_addr_i[3:2];
        r_wd = nmi_wdata_i;
        r_ws = nmi_wstrb_i;
        left = WC + 1;
      end
      acc = left == 1;
      txpop = txq.size() != 0 && tx_ready_i;
      rxpush = rx_valid_i && rxq.size() < D;
      st = 32'(txq.size()) + 32'(rxq.size()) * 256
         + (txq.size() == D ? 32'h1_0000 : 0) + (txq.size() == 0 ? 32'h2_0000 : 0)
         + (rxq.size() == D ? 32'h4_0000 : 0) + (rxq.size() == 0 ? 32'h8_0000 : 0)
         + (m_ovf ? 32'h0100_0000 : 0) + (m_udf ? 32'h0200_0000 : 0);
      if (txpop) void'(txq.pop_front());
      if (acc && r_ws == 0) begin
        if (r_off == 1) begin
          if (rxq.size() != 0) rv = rxq.pop_front();
          else m_udf = 1;
        end else if (r_off == 2) rv = st;
        else if (r_off == 3) rv = {30'd0, m_txeie, m_rxie};
      end else if (acc) begin
        if (r_off == 0) begin
          if (txq.size() < D) txq.push_back(r_wd);
          else m_ovf = 1;
        end else if (r_off == 2 && r_ws[3]) begin
          if (r_wd[24]) m_ovf = 0;
          if (r_wd[25]) m_udf = 0;
        end else if (r_off == 3) begin
          if (r_ws[0]) {m_txeie, m_rxie} = r_wd[1:0];
          fl = r_ws[1] && r_wd[8];
        end
      end
      if (rxpush) rxq.push_back(rx_data_i);
      if (fl) begin
        txq.delete();
        rxq.delete();
      end
      exp_ready = acc;
      if (acc) exp_rdata = r_ws == 0 ? rv : 0;
    end
  end
  always @(negedge clk_i) if (started) begin
    check("ready", 32'(nmi_ready_o), 32'(exp_ready));
    check("rdata", nmi_rdata_o, exp_rdata);
    check("tx_valid", 32'(tx_valid_o), 32'(txq.size() != 0));
    if (txq.size() != 0) check("tx_data", tx_data_o, txq[0]);
    check("rx_ready", 32'(rx_ready_o), 32'(rxq.size() < D));
    check("irq", 32'(irq_o), 32'((m_rxie && rxq.size() != 0) || (m_txeie && txq.size() == 0)));
  end
  task automatic access(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                        input int pop_k, output int lat, output logic [31:0] r);
    nmi_valid_i = 1;
    nmi_addr_i = a;
    nmi_wdata_i = w;
    nmi_wstrb_i = s;
    lat = 0;
    r = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      nmi_valid_i = 0;
      tx_ready_i = k == pop_k;
      if (nmi_ready_o) begin
        lat = k;
        r = nmi_rdata_o;
        break;
      end
    end
    tx_ready_i = 0;
    @(negedge clk_i);
  endtask
  task automatic xfer(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                      input int pop_k, output logic [31:0] r);
    int lat;
    access(a, w, s, pop_k, lat, r);
    check("latency", lat, WC + 1);
  endtask
  initial begin
    logic [31:0] d;
    logic [31:0] exp4 [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    int n, lat, seen;
    {rst_i, nmi_valid_i, tx_ready_i, rx_valid_i} = 4'b1000;
    nmi_addr_i = 0;
    nmi_wdata_i = 0;
    nmi_wstrb_i = 0;
    rx_data_i = 0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", 32'(nmi_ready_o), 0);
    check("rst_rdata", nmi_rdata_o, 0);
    check("rst_tx_valid", 32'(tx_valid_o), 0);
    check("rst_rx_ready", 32'(rx_ready_o), 1);
    check("rst_irq", 32'(irq_o), 0);
    rst_i = 0;
    xfer(STS, 0, 0, 0, d);
    check("status_reset", d, 32'h000A_0000);
    for (int i = 0; i < 5; i++) xfer(TXD, 32'h11 * (i + 1), 4'hF, 0, d);
    xfer(STS, 0, 0, 0, d);
    check("status_tx_ovf", d, 32'h0109_0004);
    tx_ready_i = 1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (tx_valid_o) begin
        check("drain", tx_data_o, exp4[n]);
        n++;
      end
      if (n == 4) break;
      @(negedge clk_i);
    end
    @(negedge clk_i);
    tx_ready_i = 0;
    check("drain_count", n, 4);
    xfer(STS, 32'h0100_0000, 4'hF, 0, d);
    xfer(RXD, 0, 0, 0, d);
    check("rx_empty_read", d, 0);
    xfer(STS, 0, 0, 0, d);
    check("status_udf", d, 32'h020A_0000);
    xfer(STS, 32'h0200_0000, 4'hF, 0, d);
    xfer(STS, 0, 0, 0, d);
    check("status_cleared", d, 32'h000A_0000);
    xfer(CTL, 32'h1, 4'h1, 0, d);
    rx_valid_i = 1;
    rx_data_i = 32'hCAFE;
    @(negedge clk_i);
    rx_valid_i = 0;
    check("irq_rx", 32'(irq_o), 1);
    xfer(RXD, 0, 0, 0, d);
    check("rx_cafe", d, 32'hCAFE);
    check("irq_rx_off", 32'(irq_o), 0);
    for (int i = 0; i < 4; i++) xfer(TXD, 32'hA0 + i, 4'hF, 0, d);
    xfer(TXD, 32'hB0, 4'h1, WC, d);
    xfer(STS, 0, 0, 0, d);
    check("status_full_pushpop", d, 32'h0009_0004);
    check("tx_head_after", tx_data_o, 32'hA1);
    xfer(CTL, 32'h101, 4'h3, 0, d);
    xfer(STS, 0, 0, 0, d);
    check("status_flush", d, 32'h000A_0000);
    xfer(CTL, 32'h2, 4'h1, 0, d);
    check("irq_txe", 32'(irq_o), 1);
    xfer(CTL, 0, 0, 0, d);
    check("ctrl_read", d, 32'h2);
    xfer(CTL, 0, 4'h1, 0, d);
    check("irq_txe_off", 32'(irq_o), 0);
    nmi_valid_i = 1;
    nmi_addr_i = TXD;
    nmi_wdata_i = 32'h77;
    nmi_wstrb_i = 4'hF;
    @(negedge clk_i);
    nmi_valid_i = 0;
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (nmi_ready_o) seen = 1;
      @(negedge clk_i);
    end
    check("abort_no_ready", seen, 0);
    xfer(STS, 0, 0, 0, d);
    check("abort_tx_empty", d, 32'h000A_0000);
    access(32'h2000_0008, 0, 0, 0, lat, d);
    check("unselected", lat, 0);
    rx_valid_i = 1;
    for (int i = 0; i < 6; i++) begin
      rx_data_i = 32'hD0 + i;
      @(negedge clk_i);
    end
    rx_valid_i = 0;
    xfer(STS, 0, 0, 0, d);
    check("status_rx_full", d, 32'h0006_0400);
    for (int i = 0; i < 4; i++) begin
      xfer(RXD, 0, 0, 0, d);
      check("rx_order", d, 32'hD0 + i);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nmi_mbox_resp.md
NMI_MBOX_RESP -- requirements
Module: nmi_mbox_resp

Interface
REQ-001 Parameter BASE_ADDR, 32'h1000_0000, block base address (16-byte aligned).
REQ-002 Parameter DEPTH, 4, entries per FIFO; power of two, 2..16.
REQ-003 Parameter WAIT_CYC, 0, extra wait states per access, 0..7.
REQ-004 Port clk_i  in  1  sole clock; all state on rising edge.
REQ-005 Port rst_i  in  1  reset, synchronous, active-high.
REQ-006 Port nmi_valid_i  in  1  request valid from NMI master.
REQ-007 Port nmi_ready_o  out  1  one-cycle response strobe.
REQ-008 Port nmi_addr_i  in  32  byte address.
REQ-009 Port nmi_wdata_i  in  32  write data.
REQ-010 Port nmi_wstrb_i  in  4  byte strobes; 4'b0000 = read.
REQ-011 Port nmi_rdata_o  out  32  read data, registered.
REQ-012 Port tx_valid_o / tx_ready_i / tx_data_o  out/in/out  1/1/32  TX stream out.
REQ-013 Port rx_valid_i / rx_ready_o / rx_data_i  in/out/in  1/1/32  RX stream in.
REQ-014 Port irq_o  out  1  level interrupt.

Function
REQ-015 Select = nmi_valid_i & (nmi_addr_i[31:4] == BASE_ADDR[31:4]); unselected requests never get nmi_ready_o.
REQ-016 Offsets ([3:2]): 0 TXDATA (W), 1 RXDATA (R, pops), 2 STATUS (R, W1C), 3 CTRL (RW).
REQ-017 FSM IDLE -> WAIT (WAIT_CYC cycles, skipped if 0) -> RESP -> IDLE; RESP->IDLE unconditional.
REQ-018 Access side effect and nmi_rdata_o load happen on the edge entering RESP; nmi_ready_o = 1 only in RESP.
REQ-019 Latency: select first sampled high in IDLE at cycle t -> nmi_ready_o high at cycle t+1+WAIT_CYC, exactly one cycle.
REQ-020 nmi_valid_i ignored in WAIT and RESP; request fields sampled once, on IDLE->next edge.
REQ-021 nmi_rdata_o holds last loaded value until next RESP; writes load 0.
REQ-022 TXDATA write (any nonzero wstrb): push full nmi_wdata_i; if TX full, drop and set tx_ovf.
REQ-023 RXDATA read: return head and pop; if RX empty, return 0 and set rx_udf.
REQ-024 Read of TXDATA returns 0; write to RXDATA has no effect.
REQ-025 STATUS: [4:0] tx_count, [12:8] rx_count, [16] tx_full, [17] tx_empty, [18] rx_full, [19] rx_empty, [24] tx_ovf, [25] rx_udf; others 0.
REQ-026 STATUS write: wstrb[3] & wdata[24]/[25] clears tx_ovf/rx_udf; other bits ignored.
REQ-027 CTRL: [0] rx_ie, [1] txe_ie, writable with wstrb[0]; [8] flush, write-1 with wstrb[1], self-clearing, reads 0.
REQ-028 Flush empties both FIFOs on the RESP edge; flush wins over same-cycle stream push/pop.
REQ-029 tx_valid_o = !tx_empty; tx_data_o = TX head; pop on tx_valid_o & tx_ready_i.
REQ-030 rx_ready_o = !rx_full; push rx_data_i on rx_valid_i & rx_ready_o.
REQ-031 Simultaneous push and pop on same FIFO: both take effect, count unchanged; pop from full plus push legal.
REQ-032 Counts width 5 bits; pointers wrap modulo DEPTH without loss.
REQ-033 irq_o = (rx_ie & !rx_empty) | (txe_ie & tx_empty), from registered state, no extra latency.
REQ-034 tx_data_o stable while tx_valid_o & !tx_ready_i.

Reset
REQ-035 rst_i high at an edge: FSM IDLE, nmi_ready_o 0, nmi_rdata_o 0, FIFOs empty, tx_ovf/rx_udf 0, CTRL 0.
REQ-036 Reset mid-access (WAIT or RESP): access aborted, no ready, no FIFO side effect.
REQ-037 After reset: tx_valid_o 0, rx_ready_o 1, irq_o 0.

Verification
REQ-038 WAIT_CYC=2, read STATUS at t after reset -> ready at t+3, rdata 32'h000A_0000.
REQ-039 Write 0x11,0x22,0x33,0x44,0x55 to TXDATA (DEPTH=4), tx_ready_i=0 -> tx_count 4, tx_ovf=1; drain -> tx_data_o 0x11..0x44 in order.
REQ-040 Read RXDATA when empty -> rdata 0, rx_udf=1; write STATUS 32'h0200_0000 wstrb 4'hF -> rx_udf=0.
REQ-041 CTRL=1, rx_valid_i with 0xCAFE -> irq_o 1 next cycle; read RXDATA -> 0xCAFE, irq_o 0.
REQ-042 TX full plus tx_ready_i and TXDATA write same edge -> both occur, tx_count stays 4, no ovf.
REQ-043 rst_i asserted during WAIT of TXDATA write -> no ready, tx_count 0 afterward.
